// File: rtl/captura_jogada.sv
// captura_jogada: synchronizes and debounces the push-buttons and captures one play per arm.
// Optional build macro CAPTURA_ONEHOT_CHECK_EN: only single-button patterns count as a press while waiting.
module captura_jogada #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 5000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       habilita,
    input  logic [3:0] botoes,
    output logic [3:0] jogada,
    output logic       jogada_feita,
    output logic       timeout,
    output logic       aguardando,
    output logic       db_tem_jogada,
    output logic [1:0] db_estado
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [TW-1:0] T_LIM = TW'(TIMEOUT_CYCLES);
    localparam logic [DW-1:0] D_LIM = DW'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        OCIOSO        = 2'd0,
        ESPERA_JOGADA = 2'd1,
        FILTRO        = 2'd2,
        SOLTURA       = 2'd3
    } estado_t;

    estado_t       estado_q, estado_d;
    logic [TW-1:0] cnt_t_q, cnt_t_d;
    logic [DW-1:0] cnt_d_q, cnt_d_d;
    logic [3:0]    padrao_q, padrao_d;
    logic [3:0]    botoes_r_q;
    logic [3:0]    jogada_q, jogada_d;
    logic          feita_q, feita_d;
    logic          timeout_q, timeout_d;
    logic          aguardando_q, aguardando_d;

    logic [3:0]    amostra;
    logic [TW-1:0] cnt_t_inc;
    logic          t_fim;

    always_comb begin
`ifdef CAPTURA_ONEHOT_CHECK_EN
        // A chord (two or more buttons) looks like no press at all while waiting.
        amostra = ((botoes_r_q & (botoes_r_q - 4'd1)) == 4'd0) ? botoes_r_q : 4'd0;
`else
        amostra = botoes_r_q;
`endif
        cnt_t_inc = cnt_t_q + TW'(1);
        t_fim     = (cnt_t_inc == T_LIM);
    end

    always_comb begin
        estado_d  = estado_q;
        cnt_t_d   = cnt_t_q;
        cnt_d_d   = cnt_d_q;
        padrao_d  = padrao_q;
        jogada_d  = jogada_q;
        feita_d   = 1'b0;
        timeout_d = 1'b0;
        case (estado_q)
            OCIOSO: begin
                if (habilita) begin
                    estado_d = ESPERA_JOGADA;
                    cnt_t_d  = '0;
                end
            end
            ESPERA_JOGADA: begin
                cnt_t_d = cnt_t_inc;
                if (amostra != 4'd0) begin
                    estado_d = FILTRO;
                    padrao_d = amostra;
                    cnt_d_d  = DW'(1);
                end
                if (t_fim) begin
                    estado_d  = OCIOSO;
                    timeout_d = 1'b1;
                end
            end
            FILTRO: begin
                cnt_t_d = cnt_t_inc;
                // A completed debounce takes priority over a timeout on the same edge.
                if (cnt_d_q == D_LIM) begin
                    estado_d = SOLTURA;
                    jogada_d = padrao_q;
                    feita_d  = 1'b1;
                    cnt_d_d  = '0;
                end else begin
                    if (amostra == 4'd0) begin
                        estado_d = ESPERA_JOGADA;
                    end else if (amostra == padrao_q) begin
                        cnt_d_d = cnt_d_q + DW'(1);
                    end else begin
                        padrao_d = amostra;
                        cnt_d_d  = DW'(1);
                    end
                    if (t_fim) begin
                        estado_d  = OCIOSO;
                        timeout_d = 1'b1;
                    end
                end
            end
            SOLTURA: begin
                if (botoes_r_q != 4'd0) begin
                    cnt_d_d = '0;
                end else if (cnt_d_q + DW'(1) == D_LIM) begin
                    estado_d = OCIOSO;
                    cnt_d_d  = '0;
                end else begin
                    cnt_d_d = cnt_d_q + DW'(1);
                end
            end
            default: estado_d = OCIOSO;
        endcase
        aguardando_d = (estado_d == ESPERA_JOGADA) || (estado_d == FILTRO);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q     <= OCIOSO;
            cnt_t_q      <= '0;
            cnt_d_q      <= '0;
            padrao_q     <= 4'd0;
            botoes_r_q   <= 4'd0;
            jogada_q     <= 4'd0;
            feita_q      <= 1'b0;
            timeout_q    <= 1'b0;
            aguardando_q <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            cnt_t_q      <= cnt_t_d;
            cnt_d_q      <= cnt_d_d;
            padrao_q     <= padrao_d;
            botoes_r_q   <= botoes;
            jogada_q     <= jogada_d;
            feita_q      <= feita_d;
            timeout_q    <= timeout_d;
            aguardando_q <= aguardando_d;
        end
    end

    assign jogada        = jogada_q;
    assign jogada_feita  = feita_q;
    assign timeout       = timeout_q;
    assign aguardando    = aguardando_q;
    assign db_tem_jogada = |botoes_r_q;
    assign db_estado     = estado_q;
endmodule

// File: tb/tb_captura_jogada.sv
// Bench for captura_jogada: two instances (long and short play window) share one stimulus stream;
// expected pulses come from a window-search model over the recorded button samples.
module tb_captura_jogada;
    localparam int D  = 4;
    localparam int TA = 5000;
    localparam int TB = 20;

    logic       clock = 1'b0;
    logic       reset;
    logic       habilita;
    logic [3:0] botoes;

    logic [3:0] jogada_a, jogada_b;
    logic       feita_a, feita_b, to_a, to_b, ag_a, ag_b, tem_a, tem_b;
    logic [1:0] est_a, est_b;

    captura_jogada #(.DEBOUNCE_CYCLES(D), .TIMEOUT_CYCLES(TA)) dut_a (
        .clock(clock), .reset(reset), .habilita(habilita), .botoes(botoes),
        .jogada(jogada_a), .jogada_feita(feita_a), .timeout(to_a),
        .aguardando(ag_a), .db_tem_jogada(tem_a), .db_estado(est_a)
    );

    captura_jogada #(.DEBOUNCE_CYCLES(D), .TIMEOUT_CYCLES(TB)) dut_b (
        .clock(clock), .reset(reset), .habilita(habilita), .botoes(botoes),
        .jogada(jogada_b), .jogada_feita(feita_b), .timeout(to_b),
        .aguardando(ag_b), .db_tem_jogada(tem_b), .db_estado(est_b)
    );

    // clock / reset
    always #5 clock = ~clock;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // scoreboard state: entry = {is_capture, jogada, cycle of pulse}
    int          checks = 0;
    int          errors = 0;
    logic [36:0] exp_a[$];
    logic [36:0] exp_b[$];
    logic [3:0]  last_a = 4'd0;
    logic [3:0]  last_b = 4'd0;
    logic [3:0]  raw_q[$];

    task automatic chk(input string nm, input logic [36:0] got, input logic [36:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    function automatic logic [3:0] filt(input logic [3:0] v);
`ifdef CAPTURA_ONEHOT_CHECK_EN
        return ($countones(v) == 1) ? v : 4'd0;
`else
        return v;
`endif
    endfunction

    // value the FSM sees at arm-relative edge j: the raw level sampled one edge earlier
    function automatic logic [3:0] samp(input int j);
        if (j - 1 < raw_q.size()) return filt(raw_q[j-1]);
        return 4'd0;
    endfunction

    // first edge m whose D preceding samples are one identical nonzero pattern wins, if m <= t
    task automatic predict(input int t, input int base, inout logic [3:0] last, output logic [36:0] e);
        bit         found;
        bit         ok;
        logic [3:0] v;
        found = 1'b0;
        e = {1'b0, last, 32'(base + 1 + t)};
        for (int m = D + 1; m <= t && !found; m++) begin
            v  = samp(m - D);
            ok = (v != 4'd0);
            for (int k = 1; k < D; k++) if (samp(m - D + k) != v) ok = 1'b0;
            if (ok) begin
                found = 1'b1;
                last  = v;
                e     = {1'b1, v, 32'(base + 1 + m)};
            end
        end
    endtask

    // driver: arm, play raw_q, then release long enough to return to idle
    task automatic play(input string nm, input int hab_extra);
        logic [36:0] ea, eb;
        int base;
        @(posedge clock); #1;
        base = cyc;
        predict(TA, base, last_a, ea);
        predict(TB, base, last_b, eb);
        exp_a.push_back(ea);
        exp_b.push_back(eb);
        for (int e = 0; e < raw_q.size(); e++) begin
            if (e > 0) begin @(posedge clock); #1; end
            if (e == 2) chk({nm, "_aguardando_on"}, {35'd0, ag_a, ag_b}, 37'b11);
            habilita = (e == 0) || (e == hab_extra);
            botoes   = raw_q[e];
        end
        for (int k = 0; k < D + 6; k++) begin
            @(posedge clock); #1;
            habilita = 1'b0;
            botoes   = 4'd0;
        end
        chk({nm, "_aguardando_off"}, {35'd0, ag_a, ag_b}, 37'b00);
    endtask

    task automatic fill(input logic [3:0] v, input int n);
        for (int i = 0; i < n; i++) raw_q.push_back(v);
    endtask

    // monitors: pop and compare whenever a DUT pulses
    logic [36:0] ma, mb;
    always @(negedge clock) begin
        if (feita_a && to_a) begin errors++; $display("FAIL a_exclusive cyc=%0d", cyc); end
        if (feita_a || to_a) begin
            checks++;
            if (exp_a.size() == 0) begin
                errors++;
                $display("FAIL a_unexpected feita=%0b timeout=%0b cyc=%0d", feita_a, to_a, cyc);
            end else begin
                ma = exp_a.pop_front();
                if ({feita_a, jogada_a, 32'(cyc)} !== ma) begin
                    errors++;
                    $display("FAIL a_pulse got cap=%0b jog=%h cyc=%0d exp cap=%0b jog=%h cyc=%0d",
                             feita_a, jogada_a, cyc, ma[36], ma[35:32], ma[31:0]);
                end
            end
        end
    end
    always @(negedge clock) begin
        if (feita_b && to_b) begin errors++; $display("FAIL b_exclusive cyc=%0d", cyc); end
        if (feita_b || to_b) begin
            checks++;
            if (exp_b.size() == 0) begin
                errors++;
                $display("FAIL b_unexpected feita=%0b timeout=%0b cyc=%0d", feita_b, to_b, cyc);
            end else begin
                mb = exp_b.pop_front();
                if ({feita_b, jogada_b, 32'(cyc)} !== mb) begin
                    errors++;
                    $display("FAIL b_pulse got cap=%0b jog=%h cyc=%0d exp cap=%0b jog=%h cyc=%0d",
                             feita_b, jogada_b, cyc, mb[36], mb[35:32], mb[31:0]);
                end
            end
        end
    end

    initial begin
        logic [3:0] v;
        reset = 1'b0; habilita = 1'b0; botoes = 4'd0;
        #12;
        chk("reset_a", {30'd0, jogada_a, feita_a, to_a, ag_a}, 37'd0);
        chk("reset_b", {30'd0, jogada_b, feita_b, to_b, ag_b}, 37'd0);
        @(posedge clock); #1; reset = 1'b1;
        repeat (2) @(posedge clock);

        raw_q = {}; fill(4'b0010, 2); fill(4'b1000, 10);
        play("pattern_change", -1);

        raw_q = {4'b0100, 4'b0000, 4'b0100, 4'b0000}; fill(4'b0100, 10);
        play("bounce", -1);

        // reset while both instances are in the debounce filter
        @(posedge clock); #1; habilita = 1'b1; botoes = 4'b0001;
        @(posedge clock); #1; habilita = 1'b0;
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;
        #1;
        chk("midreset_a", {30'd0, jogada_a, feita_a, to_a, ag_a}, 37'd0);
        chk("midreset_b", {30'd0, jogada_b, feita_b, to_b, ag_b}, 37'd0);
        chk("midreset_tem", {35'd0, tem_a, tem_b}, 37'd0);
        last_a = 4'd0; last_b = 4'd0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock); #1;
        chk("tem_jogada", {35'd0, tem_a, tem_b}, 37'b11);
        repeat (2) @(posedge clock);
        #1 botoes = 4'd0;
        repeat (D + 4) @(posedge clock);

        raw_q = {}; fill(4'b0001, 10);
        play("after_reset", -1);

        raw_q = {}; fill(4'b0000, 15); fill(4'b0001, 10);
        play("boundary_capture", -1);
        raw_q = {}; fill(4'b0000, 16); fill(4'b0001, 10);
        play("boundary_timeout", -1);

        raw_q = {}; fill(4'b0010, 14);
        play("hab_in_soltura", 9);
        repeat (30) @(posedge clock);

        for (int t = 0; t < 20; t++) begin
            raw_q = {};
            v = 4'd0;
            for (int i = 0; i < $urandom_range(0, 25); i++) begin
                case ($urandom_range(0, 3))
                    0: v = 4'd0;
                    1: v = 4'($urandom_range(0, 15));
                    2: v = v;
                    default: v = 4'(1 << $urandom_range(0, 3));
                endcase
                raw_q.push_back(v);
            end
            fill(4'(1 << $urandom_range(0, 3)), $urandom_range(D + 2, D + 6));
            play("random", -1);
        end

        raw_q = {};
`ifdef CAPTURA_ONEHOT_CHECK_EN
        fill(4'b0011, TA + 10);
`else
        fill(4'b0011, 30);
`endif
        play("chord", -1);

        raw_q = {}; fill(4'b0000, 5500);
        play("timeout_long", -1);

        repeat (30) @(posedge clock);
        chk("queue_a_drained", 37'(exp_a.size()), 37'd0);
        chk("queue_b_drained", 37'(exp_b.size()), 37'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
